// File: rtl/exec_md_pkg.sv
// Shared definitions for the multi-cycle execute stage.
//   - 4-bit ALU op codes (OP_AND .. OP_NOP)
//   - FSM state type for the execute-stage sequencer
//   - sext_shift2: sign-extends a word offset and converts it to a byte offset
package exec_md_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // Works on a 64-bit container so it serves any XLEN up to 64; the caller
  // truncates the result to its datapath width (wrap-around is intended).
  function automatic logic [63:0] sext_shift2(input logic [63:0] imm, input int imm_w);
    logic [63:0] ext;
    for (int i = 0; i < 64; i++) begin
      ext[i] = (i < imm_w) ? imm[i] : imm[imm_w-1];
    end
    return ext << 2;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply / unsigned divide / unsigned remainder, one bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load operands and begin (ignored while busy)
//   abort_i    : drop the operation in progress
//   op_i       : OP_MUL, OP_DIVU or OP_REMU
//   a_i, b_i   : operands (multiplicand/multiplier or dividend/divisor)
//   busy_o     : an operation is in progress
//   done_o     : final step happens at the coming edge; result_o is valid now
//   result_o   : result including the final step (combinational)
module muldiv_iter
  import exec_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  // x: multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
  // y: multiplier (MUL) or divisor
  // acc: product accumulator (MUL) or partial remainder (DIV/REM)
  logic [XLEN-1:0]  x_q, x_d, y_q, y_d, acc_q, acc_d;

  logic [XLEN:0]    trial;
  logic             fits;
  logic [XLEN-1:0]  x_step, y_step, acc_step;

  // One shift-add or restoring-subtract step. A zero divisor always "fits",
  // which naturally yields an all-ones quotient and remainder == dividend.
  always_comb begin
    trial = {acc_q, x_q[XLEN-1]};
    fits  = (trial >= {1'b0, y_q});
    if (op_q == OP_MUL) begin
      acc_step = y_q[0] ? (acc_q + x_q) : acc_q;
      x_step   = x_q << 1;
      y_step   = y_q >> 1;
    end else begin
      acc_step = fits ? XLEN'(trial - {1'b0, y_q}) : trial[XLEN-1:0];
      x_step   = {x_q[XLEN-2:0], fits};
      y_step   = y_q;
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(XLEN);
      op_d   = op_i;
      x_d    = a_i;
      y_d    = b_i;
      acc_d  = '0;
    end else if (busy_q) begin
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
      x_d    = x_step;
      y_d    = y_step;
      acc_d  = acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_NOP;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

  // Datapath registers carry no reset; they are always reloaded on start.
  always_ff @(posedge clk) begin
    x_q   <= x_d;
    y_q   <= y_d;
    acc_q <= acc_d;
  end

  assign busy_o   = busy_q;
  assign done_o   = busy_q && (cnt_q == CNT_W'(1));
  assign result_o = (op_q == OP_DIVU) ? x_step : acc_step;

endmodule

// File: rtl/exec_stage_md.sv
// Execute stage with valid/ready toward decode, extended ALU, branch
// resolution and an optional iterative MUL/DIVU/REMU unit.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : kill the in-flight or accepting instruction
//   dx_valid / dx_ready   : handshake with ID/EX (ready = sequencer idle)
//   dx_alu_ctr, dx_*      : op code, control bits, npc, operands, imm, rd, store data
//   xm_valid, xm_*        : EX/MEM register contents (MEM always accepts)
module exec_stage_md
  import exec_md_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IMM_W     = 16,
  parameter int RD_W      = 5,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dx_valid,
  output logic             dx_ready,
  input  logic [3:0]       dx_alu_ctr,
  input  logic             dx_memtoreg,
  input  logic             dx_regwrite,
  input  logic             dx_memread,
  input  logic             dx_memwrite,
  input  logic             dx_branch,
  input  logic [XLEN-1:0]  dx_npc,
  input  logic [XLEN-1:0]  dx_a,
  input  logic [XLEN-1:0]  dx_b,
  input  logic [IMM_W-1:0] dx_imm,
  input  logic [RD_W-1:0]  dx_rd,
  input  logic [XLEN-1:0]  dx_md,
  output logic             xm_valid,
  output logic             xm_memtoreg,
  output logic             xm_regwrite,
  output logic             xm_memread,
  output logic             xm_memwrite,
  output logic             xm_branch,
  output logic [XLEN-1:0]  xm_aluout,
  output logic [XLEN-1:0]  xm_bt,
  output logic [RD_W-1:0]  xm_rd,
  output logic [XLEN-1:0]  xm_md
);

  localparam int SH_W = $clog2(XLEN);

  state_e           state_q, state_d;
  logic             accept, is_md, md_start, md_complete;
  logic             md_busy, md_done;
  logic [XLEN-1:0]  md_result;
  logic [XLEN-1:0]  alu_res, bt;
  logic             br_taken;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [SH_W-1:0]  sh;

  // Context held while the iterative unit works: {memtoreg, regwrite, memread, memwrite}
  logic [3:0]       ctx_ctl_q;
  logic [XLEN-1:0]  ctx_bt_q, ctx_md_q;
  logic [RD_W-1:0]  ctx_rd_q;

  // EX/MEM register; ctl is {memtoreg, regwrite, memread, memwrite, branch}
  logic             valid_q, valid_d;
  logic [4:0]       ctl_q, ctl_d;
  logic [XLEN-1:0]  alu_q, alu_d, bt_q, bt_d, md_q, md_d;
  logic [RD_W-1:0]  rd_q, rd_d;

  assign accept   = dx_valid && dx_ready && !flush;
  assign is_md    = (MULDIV_EN != 0) &&
                    ((dx_alu_ctr == OP_MUL) || (dx_alu_ctr == OP_DIVU) || (dx_alu_ctr == OP_REMU));
  assign md_start = accept && is_md;

  // ---- ALU and branch resolution ----
  assign a_s = $signed(dx_a);
  assign b_s = $signed(dx_b);
  assign sh  = dx_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (dx_alu_ctr)
      OP_AND:                 alu_res = dx_a & dx_b;
      OP_OR:                  alu_res = dx_a | dx_b;
      OP_ADD:                 alu_res = dx_a + dx_b;
      OP_XOR:                 alu_res = dx_a ^ dx_b;
      OP_NOR:                 alu_res = ~(dx_a | dx_b);
      OP_BEQ, OP_BNE, OP_SUB: alu_res = dx_a - dx_b;
      OP_SLT:                 alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLL:                 alu_res = dx_a << sh;
      OP_SRL:                 alu_res = dx_a >> sh;
      OP_SRA:                 alu_res = $unsigned(a_s >>> sh);
      default:                alu_res = '0;  // MUL/DIVU/REMU handled iteratively, NOP gives 0
    endcase
  end

  assign br_taken = dx_branch && (((dx_alu_ctr == OP_BEQ) && (dx_a == dx_b)) ||
                                  ((dx_alu_ctr == OP_BNE) && (dx_a != dx_b)));
  assign bt = dx_npc + XLEN'(sext_shift2(64'(dx_imm), IMM_W));

  // ---- Iterative multiply/divide ----
  generate
    if (MULDIV_EN != 0) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .abort_i  (flush),
        .op_i     (dx_alu_ctr),
        .a_i      (dx_a),
        .b_i      (dx_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
      );
    end else begin : g_no_md
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (md_start) begin
      ctx_ctl_q <= {dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite};
      ctx_bt_q  <= bt;
      ctx_rd_q  <= dx_rd;
      ctx_md_q  <= dx_md;
    end
  end

  // ---- Sequencer: state register / next state / outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (md_start)           state_d = BUSY;
      BUSY: if (flush || md_done)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    dx_ready    = (state_q == IDLE);
    md_complete = (state_q == BUSY) && md_busy && md_done && !flush;
  end

  // ---- EX/MEM register ----
  // Bubbles clear valid and controls but leave the data fields untouched.
  always_comb begin
    valid_d = 1'b0;
    ctl_d   = '0;
    alu_d   = alu_q;
    bt_d    = bt_q;
    rd_d    = rd_q;
    md_d    = md_q;
    if (accept && !is_md) begin
      valid_d = 1'b1;
      ctl_d   = {dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, br_taken};
      alu_d   = alu_res;
      bt_d    = bt;
      rd_d    = dx_rd;
      md_d    = dx_md;
    end else if (md_complete) begin
      valid_d = 1'b1;
      ctl_d   = {ctx_ctl_q, 1'b0};
      alu_d   = md_result;
      bt_d    = ctx_bt_q;
      rd_d    = ctx_rd_q;
      md_d    = ctx_md_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      alu_q   <= '0;
      bt_q    <= '0;
      rd_q    <= '0;
      md_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      alu_q   <= alu_d;
      bt_q    <= bt_d;
      rd_q    <= rd_d;
      md_q    <= md_d;
    end
  end

  assign xm_valid = valid_q;
  assign {xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch} = ctl_q;
  assign xm_aluout = alu_q;
  assign xm_bt     = bt_q;
  assign xm_rd     = rd_q;
  assign xm_md     = md_q;

endmodule

// File: tb/tb_exec_stage_md.sv
module tb_exec_stage_md;

  localparam int XLEN  = 32;
  localparam int IMM_W = 16;
  localparam int RD_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n, flush, dx_valid, dx_ready;
  logic [3:0]       dx_alu_ctr;
  logic             dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch;
  logic [XLEN-1:0]  dx_npc, dx_a, dx_b, dx_md;
  logic [IMM_W-1:0] dx_imm;
  logic [RD_W-1:0]  dx_rd;
  logic             xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch;
  logic [XLEN-1:0]  xm_aluout, xm_bt, xm_md;
  logic [RD_W-1:0]  xm_rd;

  exec_stage_md #(.XLEN(XLEN), .IMM_W(IMM_W), .RD_W(RD_W), .MULDIV_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dx_valid(dx_valid), .dx_ready(dx_ready), .dx_alu_ctr(dx_alu_ctr),
    .dx_memtoreg(dx_memtoreg), .dx_regwrite(dx_regwrite), .dx_memread(dx_memread),
    .dx_memwrite(dx_memwrite), .dx_branch(dx_branch),
    .dx_npc(dx_npc), .dx_a(dx_a), .dx_b(dx_b), .dx_imm(dx_imm), .dx_rd(dx_rd), .dx_md(dx_md),
    .xm_valid(xm_valid), .xm_memtoreg(xm_memtoreg), .xm_regwrite(xm_regwrite),
    .xm_memread(xm_memread), .xm_memwrite(xm_memwrite), .xm_branch(xm_branch),
    .xm_aluout(xm_aluout), .xm_bt(xm_bt), .xm_rd(xm_rd), .xm_md(xm_md)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, npc, md;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic        mtr, rw, mr, mw, br;
  } instr_t;

  typedef struct {
    logic [31:0] alu, bt, md;
    logic [4:0]  rd;
    logic [4:0]  ctl;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          free_at;
  int          checks, passes;
  bit          mon_en;
  logic [31:0] last_alu, last_md;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic bit is_md(input logic [3:0] op);
    return (op == 4'd12) || (op == 4'd13) || (op == 4'd14);
  endfunction

  // Reference model: result of one instruction from the op-code table
  function automatic exp_t model(input instr_t t, input int at);
    exp_t        e;
    logic [63:0] prod;
    logic [31:0] r;
    logic        taken;
    logic [31:0] off;
    case (t.op)
      4'd0:  r = t.a & t.b;
      4'd1:  r = t.a | t.b;
      4'd2:  r = t.a + t.b;
      4'd3:  r = t.a ^ t.b;
      4'd4:  r = ~(t.a | t.b);
      4'd5, 4'd6, 4'd8: r = t.a - t.b;
      4'd7:  r = ($signed(t.a) < $signed(t.b)) ? 32'd1 : 32'd0;
      4'd9:  r = t.a << t.b[4:0];
      4'd10: r = t.a >> t.b[4:0];
      4'd11: r = 32'($signed(t.a) >>> t.b[4:0]);
      4'd12: begin prod = 64'(t.a) * 64'(t.b); r = prod[31:0]; end
      4'd13: r = (t.b == 0) ? 32'hFFFF_FFFF : t.a / t.b;
      4'd14: r = (t.b == 0) ? t.a : t.a % t.b;
      default: r = 32'd0;
    endcase
    taken = t.br && (((t.op == 4'd5) && (t.a == t.b)) || ((t.op == 4'd6) && (t.a != t.b)));
    off   = 32'($signed(t.imm)) * 32'd4;
    e.alu = r;
    e.bt  = t.npc + off;
    e.rd  = t.rd;
    e.md  = t.md;
    e.ctl = {t.mtr, t.rw, t.mr, t.mw, taken};
    e.cyc = at;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      exp_t e;
      chk(dx_ready === (cyc >= free_at), "dx_ready", {31'b0, dx_ready}, {31'b0, (cyc >= free_at)});
      if (xm_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_xm_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk(cyc == e.cyc, "latency_cycle", 32'(cyc), 32'(e.cyc));
          chk(xm_aluout === e.alu, "xm_aluout", xm_aluout, e.alu);
          chk(xm_bt === e.bt, "xm_bt", xm_bt, e.bt);
          chk((xm_rd === e.rd) && (xm_md === e.md), "xm_rd_md", {xm_rd, xm_md[26:0]}, {e.rd, e.md[26:0]});
          chk({xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch} === e.ctl, "xm_ctrl",
              {27'b0, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch}, {27'b0, e.ctl});
          last_alu = e.alu;
          last_md  = e.md;
        end
      end else begin
        chk({xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch} === 5'b0, "bubble_ctrl",
            {27'b0, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch}, 32'd0);
        chk((xm_aluout === last_alu) && (xm_md === last_md), "bubble_hold", xm_aluout, last_alu);
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk(1'b0, "missing_result", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic next_slot();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input instr_t t);
    dx_alu_ctr  = t.op;  dx_a = t.a;  dx_b = t.b;  dx_npc = t.npc;  dx_imm = t.imm;
    dx_rd       = t.rd;  dx_md = t.md;
    dx_memtoreg = t.mtr; dx_regwrite = t.rw; dx_memread = t.mr;
    dx_memwrite = t.mw;  dx_branch = t.br;
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    instr_t t;
    t.op = op; t.a = a; t.b = b; t.npc = 32'h100; t.imm = 16'd1; t.rd = 5'd3; t.md = 32'h5A5A_0001;
    t.mtr = 1'b0; t.rw = 1'b1; t.mr = 1'b0; t.mw = 1'b0; t.br = 1'b0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.op = 4'($urandom_range(0, 15));
    if (is_md(t.op) && $urandom_range(0, 2) != 0) t.op = 4'($urandom_range(0, 11));
    case ($urandom_range(0, 3))
      0: begin t.a = $urandom_range(0, 15); t.b = $urandom_range(0, 15); end
      1: begin t.a = $urandom; t.b = $urandom; end
      2: begin t.a = $urandom; t.b = t.a; end
      default: begin t.a = $urandom; t.b = 32'd0; end
    endcase
    t.npc = $urandom & 32'hFFFF_FFFC;
    t.imm = 16'($urandom);
    t.rd  = 5'($urandom);
    t.md  = $urandom;
    {t.mtr, t.rw, t.mr, t.mw, t.br} = 5'($urandom);
    return t;
  endfunction

  // Present an instruction until accepted; schedule its expected result
  task automatic issue(input instr_t t);
    int   w = 0;
    exp_t e;
    drive(t);
    dx_valid = 1'b1;
    flush    = 1'b0;
    while (!dx_ready && w < 100) begin next_slot(); w++; end
    if (!dx_ready) begin
      chk(1'b0, "accept_timeout", 32'd0, 32'd1);
    end else begin
      e = model(t, cyc + 1 + (is_md(t.op) ? XLEN : 0));
      q.push_back(e);
      if (is_md(t.op)) free_at = cyc + 1 + XLEN;
    end
    next_slot();
    dx_valid = 1'b0;
  endtask

  // One cycle of flush, optionally with a valid instruction that must be refused
  task automatic flush_slot(input instr_t t, input bit vld);
    drive(t);
    dx_valid = vld;
    flush    = 1'b1;
    if (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    if (free_at > cyc + 1) free_at = cyc + 1;
    next_slot();
    flush    = 1'b0;
    dx_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk((xm_valid === 1'b0) &&
        ({xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch} === 5'b0),
        {tag, "_ctrl"}, {26'b0, xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch}, 32'd0);
    chk(xm_aluout === 32'd0, {tag, "_aluout"}, xm_aluout, 32'd0);
    chk(xm_bt === 32'd0, {tag, "_bt"}, xm_bt, 32'd0);
    chk((xm_rd === 5'd0) && (xm_md === 32'd0), {tag, "_rd_md"}, xm_md | 32'(xm_rd), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t t;
    int     w;
    int     r;
    rst_n = 1'b0; flush = 1'b0; dx_valid = 1'b0; mon_en = 1'b0;
    checks = 0; passes = 0; free_at = 0; last_alu = 0; last_md = 0;
    drive(mk(4'd15, 0, 0));

    // Power-on reset
    repeat (2) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk(dx_ready === 1'b1, "ready_after_reset", {31'b0, dx_ready}, 32'd1);
    mon_en = 1'b1;
    next_slot();

    // ALU sweep, back-to-back
    issue(mk(4'd8, 32'd5, 32'd7));
    issue(mk(4'd7, 32'hFFFF_FFFF, 32'd1));
    issue(mk(4'd11, 32'h8000_0000, 32'd4));
    issue(mk(4'd4, 32'h0F0F_0000, 32'h0000_00FF));
    issue(mk(4'd9, 32'h0000_0001, 32'd31));

    // Branches
    t = mk(4'd6, 32'd3, 32'd4); t.br = 1'b1; t.imm = 16'hFFFF; t.rw = 1'b0;
    issue(t);
    t = mk(4'd5, 32'd9, 32'd9); t.br = 1'b0;
    issue(t);
    t = mk(4'd5, 32'd9, 32'd9); t.br = 1'b1; t.imm = 16'h7FFF;
    issue(t);

    // Multi-cycle ops, including divide by zero and a follower stalled behind MUL
    issue(mk(4'd12, 32'h0001_0000, 32'h0001_0001));
    issue(mk(4'd2, 32'd10, 32'd20));
    issue(mk(4'd13, 32'd100, 32'd7));
    issue(mk(4'd14, 32'd100, 32'd7));
    issue(mk(4'd13, 32'd5, 32'd0));
    issue(mk(4'd14, 32'd5, 32'd0));

    // Bubble hygiene after a store
    t = mk(4'd2, 32'h40, 32'h4); t.mw = 1'b1; t.rw = 1'b0;
    issue(t);
    repeat (3) next_slot();

    // Flush in the middle of a DIVU, then an ADD
    issue(mk(4'd13, 32'd1000, 32'd3));
    repeat (8) next_slot();
    flush_slot(mk(4'd2, 32'd1, 32'd1), 1'b1);
    issue(mk(4'd2, 32'd2, 32'd3));

    // Flush while idle must refuse the presented instruction
    flush_slot(mk(4'd2, 32'd7, 32'd7), 1'b1);

    // Asynchronous reset in the middle of BUSY
    issue(mk(4'd12, 32'h1234_5678, 32'h9ABC_DEF0));
    repeat (5) next_slot();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_busy");
    q.delete();
    free_at = 0; last_alu = 0; last_md = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk(dx_ready === 1'b1, "ready_after_busy_reset", {31'b0, dx_ready}, 32'd1);
    next_slot();

    // Randomized traffic with idles and flushes
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       flush_slot(rand_instr(), 1'($urandom_range(0, 1)));
      else if (r < 30) next_slot();
      else             issue(rand_instr());
    end

    // Drain outstanding results
    w = 0;
    while (q.size() > 0 && w < 200) begin next_slot(); w++; end
    if (q.size() > 0) chk(1'b0, "drain", 32'(q.size()), 32'd0);
    repeat (2) next_slot();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exec_stage_md.md
Name: exec_stage_md

Overview:
- Parametrised successor to the single-cycle EX stage of the 5-stage pipeline; sits between the ID/EX and EX/MEM registers.
- Adds the following over the single-cycle stage:
  - valid/ready handshake toward decode;
  - extended ALU (xor, nor, shifts, signed slt);
  - iterative multi-cycle MUL/DIVU/REMU that stalls decode;
  - synchronous flush from branch resolution.
- Downstream (MEM) always accepts.

Parameters:
- XLEN, 32, datapath width (≥8, power of 2)
- IMM_W, 16, immediate width (≤XLEN-2)
- RD_W, 5, destination register index width
- MULDIV_EN, 1, 0 removes the iterative unit; ops 12-14 then complete in 1 cycle with result 0

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill in-flight/accepting instruction
- dx_valid  in  1  ID/EX holds an instruction
- dx_ready  out  1  stage can accept (combinational, =state IDLE)
- dx_alu_ctr  in  4  op code, see Behaviour
- dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch  in  1 each  control bits
- dx_npc  in  XLEN  PC+4
- dx_a, dx_b  in  XLEN  operands
- dx_imm  in  IMM_W  branch offset (words)
- dx_rd  in  RD_W  destination
- dx_md  in  XLEN  store data
- xm_valid  out  1  EX/MEM holds a result
- xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch  out  1 each  registered controls
- xm_aluout  out  XLEN  result
- xm_bt  out  XLEN  branch target
- xm_rd  out  RD_W  destination
- xm_md  out  XLEN  store data

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM IDLE, counter 0.
- accept = dx_valid & dx_ready & !flush.
- Ops:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 BEQ, 6 BNE
  - 7 SLT (signed; result 1 or 0), 8 SUB
  - 9 SLL, 10 SRL, 11 SRA (shift amount = dx_b[log2(XLEN)-1:0])
  - 12 MUL (low XLEN of unsigned product), 13 DIVU, 14 REMU, 15 NOP (result 0)
  - BEQ/BNE produce aluout = a-b.
- Branch resolution:
  - xm_branch = dx_branch & ((op==5 & a==b) | (op==6 & a!=b)).
  - xm_bt = npc + (sign-extended imm << 2), computed mod 2^XLEN.
- Single-cycle op: on accept, all xm_* loaded at the next edge with xm_valid=1 (latency 1).
- Cycles with no accept and no completion: xm_valid=0 and xm_regwrite/memread/memwrite/branch/memtoreg forced 0. xm_aluout/bt/rd/md hold their previous values.
- FSM IDLE→BUSY on accept of ops 12-14 (MULDIV_EN=1):
  - Latch operands, op, rd, md and controls.
  - xm_valid=0 that edge; counter=XLEN.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle; counter decrements each cycle.
  - When counter reaches 1, the next edge loads xm_* from the latched context with xm_valid=1 and returns to IDLE.
  - Latency accept→xm_valid = XLEN+1 edges.
  - dx_ready=0 throughout BUSY.
- Divide by zero: DIVU gives all-ones, REMU gives the dividend; takes the same XLEN+1 latency.
- flush=1:
  - Synchronous.
  - No accept that cycle.
  - BUSY aborts to IDLE with no output.
  - Next edge xm_valid=0 with controls zeroed.
  - flush wins over completion in the same cycle.
- Reset mid-BUSY: immediate IDLE with all outputs zero.
- Back-to-back: an instruction presented on the cycle the FSM returns to IDLE is accepted on the following cycle (ready is low in the completion cycle).

Decomposition:
- Package exec_md_pkg holds:
  - op-code localparams OP_AND..OP_NOP (4-bit);
  - FSM state enum {IDLE, BUSY};
  - function sext_shift2 (branch target offset).
- Sub-module muldiv_iter (start, op, a, b → busy, done, result), XLEN-parametrised, containing counter and shift/subtract datapath; top holds ALU, FSM glue and EX/MEM registers.

Test Plan:
- Reset: hold rst_n=0 mid-cycle → all outputs 0 immediately, dx_ready=1 after release.
- ALU sweep (XLEN=32):
  - SUB a=5, b=7 → xm_aluout=0xFFFFFFFE.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SRA a=0x80000000, b=4 → 0xF8000000.
  - Each result appears 1 cycle after accept with xm_valid=1.
- Branch:
  - BNE, dx_branch=1, a=3, b=4, npc=0x100, imm=0xFFFF → xm_branch=1, xm_bt=0xFC.
  - BEQ with a=b, dx_branch=0 → xm_branch=0.
- MUL/DIV (XLEN=32):
  - MUL 0x10000×0x10001 → 0x00010000 after 33 edges, dx_ready low for 32 cycles.
  - DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF.
- Flush: start DIVU, assert flush at cycle 10 → no xm_valid, dx_ready=1 next cycle, next ADD 2+3 → 5 one cycle later.
- Bubble hygiene: dx_valid=0 for 3 cycles after a MemWrite instruction → xm_memwrite=0 and xm_valid=0 on each of those cycles, xm_aluout held.
